// File: rtl/cla_pkg.sv
// Shared types and elaboration-time helpers for the pipelined CLA adder/subtractor.
// The per-stage partial sum is held beside stage_ctl_t because its width grows stage by stage.
package cla_pkg;

    localparam int CLA_MAX_W = 128;

    typedef struct packed {
        logic valid;
        logic carry;
        logic sat;
    } stage_ctl_t;

    function automatic int seg_w(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit cfg_ok(input int width, input int stages, input int block);
        return (stages >= 1) && (block >= 1) && (width <= CLA_MAX_W) &&
               (width % (stages * block) == 0);
    endfunction

    function automatic logic [CLA_MAX_W-1:0] smax(input int width);
        logic [CLA_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < width - 1; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [CLA_MAX_W-1:0] smin(input int width);
        logic [CLA_MAX_W-1:0] v;
        v = '0;
        v[width-1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/cla_seg_adder.sv
// Combinational segment adder: BLOCK-wide lookahead groups with group generate/propagate.
// c_msb is the carry into the segment MSB, used for signed-overflow detection.
module cla_seg_adder
    import cla_pkg::*;
#(
    parameter int SEG   = 16,
    parameter int BLOCK = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           c_in,
    output logic [SEG-1:0] sum,
    output logic           c_out,
    output logic           c_msb
);

    localparam int NG = SEG / BLOCK;

    logic [SEG-1:0] p, g, carry;
    logic [NG-1:0]  gg, gp;
    logic [NG:0]    cg;

    // NOTE: every variable gets a default at the top of the block so no path leaves one unassigned (no latch).
    always_comb begin
        p     = a ^ b;
        g     = a & b;
        gg    = '0;
        gp    = '1;
        cg    = '0;
        carry = '0;
        cg[0] = c_in;
        for (int j = 0; j < NG; j++) begin
            for (int i = 0; i < BLOCK; i++) begin
                gg[j] = g[j*BLOCK+i] | (p[j*BLOCK+i] & gg[j]);
                gp[j] = gp[j] & p[j*BLOCK+i];
            end
            cg[j+1] = gg[j] | (gp[j] & cg[j]);
        end
        // Bit carries inside each group start from that group's lookahead carry-in.
        for (int j = 0; j < NG; j++) begin
            carry[j*BLOCK] = cg[j];
            for (int i = 1; i < BLOCK; i++) begin
                carry[j*BLOCK+i] = g[j*BLOCK+i-1] | (p[j*BLOCK+i-1] & carry[j*BLOCK+i-1]);
            end
        end
        sum   = p ^ carry;
        c_out = cg[NG];
        c_msb = carry[SEG-1];
    end

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined CLA adder/subtractor: one carry-chained segment per stage, global-enable stall.
// Optional saturation on signed overflow is built when CLA_SATURATE_EN is defined (adds port sat).
module cla_pipe_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int BLOCK  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
`ifdef CLA_SATURATE_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int SEG = seg_w(WIDTH, STAGES);
    localparam logic [CLA_MAX_W-1:0] SMAX_FULL = smax(WIDTH);
    localparam logic [CLA_MAX_W-1:0] SMIN_FULL = smin(WIDTH);
    localparam logic [WIDTH-1:0]     SMAX      = SMAX_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0]     SMIN      = SMIN_FULL[WIDTH-1:0];

    if (!cfg_ok(WIDTH, STAGES, BLOCK)) begin : g_bad_cfg
        $error("cla_pipe_addsub: WIDTH must be a multiple of STAGES*BLOCK");
    end

    logic             en, eff_c, sat_in;
    logic [WIDTH-1:0] eff_b;
    logic             out_valid_d, out_valid_q, c_out_d, c_out_q, ovf_d, ovf_q, zero_d, zero_q;
    logic [WIDTH-1:0] res_d, res_q;

`ifdef CLA_SATURATE_EN
    assign sat_in = sat;
`else
    assign sat_in = 1'b0;
`endif

    assign en       = !(out_valid_q && !out_ready);
    assign in_ready = en;
    assign eff_b    = sub ? ~b : b;
    assign eff_c    = sub ^ c_in;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        logic [SEG-1:0] sa, sb, ss;
        logic           ci, co, cm, v_i, sat_i;

        if (k == 0) begin : g_src
            assign sa    = a[SEG-1:0];
            assign sb    = eff_b[SEG-1:0];
            assign ci    = eff_c;
            assign v_i   = in_valid;
            assign sat_i = sat_in;
        end else begin : g_src
            assign sa    = g_st[k-1].g_reg.a_q[SEG-1:0];
            assign sb    = g_st[k-1].g_reg.b_q[SEG-1:0];
            assign ci    = g_st[k-1].g_reg.ctl_q.carry;
            assign v_i   = g_st[k-1].g_reg.ctl_q.valid;
            assign sat_i = g_st[k-1].g_reg.ctl_q.sat;
        end

        cla_seg_adder #(.SEG(SEG), .BLOCK(BLOCK)) u_seg (
            .a     (sa),
            .b     (sb),
            .c_in  (ci),
            .sum   (ss),
            .c_out (co),
            .c_msb (cm)
        );

        if (k < STAGES - 1) begin : g_reg
            localparam int HI = (k + 1) * SEG;
            localparam int RW = WIDTH - HI;

            // Upper operand slices wait for their stage; finished low sum slices ride along.
            logic [RW-1:0] a_d, a_q, b_d, b_q;
            logic [HI-1:0] sum_d, sum_q;
            stage_ctl_t    ctl_d, ctl_q;

            if (k == 0) begin : g_ld
                assign a_d   = a[WIDTH-1:HI];
                assign b_d   = eff_b[WIDTH-1:HI];
                assign sum_d = ss;
            end else begin : g_ld
                assign a_d   = g_st[k-1].g_reg.a_q[RW+SEG-1:SEG];
                assign b_d   = g_st[k-1].g_reg.b_q[RW+SEG-1:SEG];
                assign sum_d = {ss, g_st[k-1].g_reg.sum_q};
            end

            assign ctl_d = '{valid: v_i, carry: co, sat: sat_i};

            // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)  ctl_q <= '0;
                else if (en) ctl_q <= ctl_d;
            end

            // NOTE: datapath flops carry no reset; their contents are only meaningful under ctl_q.valid.
            always_ff @(posedge clk) begin
                if (en) begin
                    a_q   <= a_d;
                    b_q   <= b_d;
                    sum_q <= sum_d;
                end
            end
        end else begin : g_fin
            logic [WIDTH-1:0] res_raw;

            if (k == 0) begin : g_lo
                assign res_raw = ss;
            end else begin : g_lo
                assign res_raw = {ss, g_st[k-1].g_reg.sum_q};
            end

            always_comb begin
                out_valid_d = v_i;
                c_out_d     = co;
                ovf_d       = cm ^ co;
                res_d       = res_raw;
                // On overflow the wrapped MSB is the inverse of the true sign.
                if (sat_i && ovf_d) res_d = res_raw[WIDTH-1] ? SMAX : SMIN;
                zero_d      = (res_d == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else if (en) begin
            out_valid_q <= out_valid_d;
            if (out_valid_d) begin
                res_q   <= res_d;
                c_out_q <= c_out_d;
                ovf_q   <= ovf_d;
                zero_q  <= zero_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign res_sum   = res_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Self-checking bench for cla_pipe_addsub (WIDTH=32, STAGES=2, BLOCK=4): directed steps plus
// random traffic scored against an integer-arithmetic reference model.
module tb_cla_pipe_addsub;

    typedef struct packed {
        logic [31:0] res;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, c_in, sub, sat, out_valid, out_ready;
    logic        c_out, ovf, zero;
    logic [31:0] a, b, res_sum;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t q[$];

    always #5 clk = ~clk;

    cla_pipe_addsub #(.WIDTH(32), .STAGES(2), .BLOCK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
`ifdef CLA_SATURATE_EN
        .sat       (sat),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_sum   (res_sum),
        .c_out     (c_out),
        .ovf       (ovf),
        .zero      (zero)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: true integer sums; unsigned one gives result and carry, signed one gives overflow.
    function automatic exp_t model(input logic [31:0] ia, input logic [31:0] ib,
                                   input logic ci, input logic s, input logic st);
        exp_t   e;
        longint ua, ub, sa, sb, tot, ssum, lci;
        ua  = longint'({32'b0, ia});
        ub  = longint'({32'b0, ib});
        sa  = longint'($signed(ia));
        sb  = longint'($signed(ib));
        lci = longint'({63'b0, ci});
        if (!s) begin
            tot  = ua + ub + lci;
            ssum = sa + sb + lci;
        end else begin
            tot  = ua + (64'sh0_FFFF_FFFF - ub) + (64'sd1 - lci);
            ssum = sa - sb - lci;
        end
        e.c   = tot[32];
        e.v   = (ssum > 64'sh7FFF_FFFF) || (ssum < -64'sh8000_0000);
        e.res = tot[31:0];
        if (st && e.v) e.res = (ssum > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        e.z   = (e.res == 32'h0);
        return e;
    endfunction

    function automatic logic [63:0] observed();
        return {29'b0, res_sum, c_out, ovf, zero};
    endfunction

    task automatic run_single(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                              input logic ci, input logic s, input logic st);
        exp_t e;
        e        = model(ia, ib, ci, s, st);
        in_valid = 1'b1; a = ia; b = ib; c_in = ci; sub = s; sat = st;
        step();
        in_valid = 1'b0;
        check({tag, "_lat1_valid"}, {63'b0, out_valid}, 64'd0);
        step();
        check({tag, "_lat2_valid"}, {63'b0, out_valid}, 64'd1);
        check(tag, observed(), {29'b0, e});
    endtask

    initial begin
        exp_t e_new;
        logic acc, drn;

        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c_in = 1'b0; sub = 1'b0; sat = 1'b0;

        // Reset state, during and after release
        #2 rst_n = 1'b0;
        step();
        step();
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_res_sum",   {32'b0, res_sum}, 64'd0);
        check("rst_flags",     {61'b0, c_out, ovf, zero}, 64'd0);
        check("rst_in_ready",  {63'b0, in_ready}, 64'd1);
        rst_n = 1'b1;
        #1;
        check("rel_out_valid", {63'b0, out_valid}, 64'd0);
        check("rel_res_sum",   {32'b0, res_sum}, 64'd0);
        check("rel_in_ready",  {63'b0, in_ready}, 64'd1);
        step();

        // Wrap to zero with carry out
        run_single("wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0);
        check("wrap_lit", observed(), {29'b0, 32'h0, 1'b1, 1'b0, 1'b1});

        // Signed-overflow subtraction
        run_single("sub_ovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 1'b0);
        check("sub_ovf_lit", observed(), {29'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0});
`ifdef CLA_SATURATE_EN
        run_single("sub_sat", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 1'b1);
        check("sub_sat_lit", {32'b0, res_sum}, {32'b0, 32'h8000_0000});
        run_single("add_sat", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1);
        check("add_sat_lit", {32'b0, res_sum}, {32'b0, 32'h7FFF_FFFF});
`endif

        // Carry across the segment boundary; subtract with borrow-in
        run_single("seg_carry", 32'h0000_FFFF, 32'h1, 1'b0, 1'b0, 1'b0);
        check("seg_carry_lit", {32'b0, res_sum}, {32'b0, 32'h0001_0000});
        run_single("sub_bin", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 1'b0);
        check("sub_bin_lit", {32'b0, res_sum}, {32'b0, 32'hFFFF_FFFD});
        step();

        // Back-to-back ops with a 3-cycle output stall
        in_valid = 1'b1; a = 32'd1; b = 32'd1; c_in = 1'b0; sub = 1'b0; sat = 1'b0;
        step();
        a = 32'd2; b = 32'd2;
        step();
        a = 32'd3; b = 32'd3; out_ready = 1'b0;
        #1;
        check("stall_first", {31'b0, out_valid, res_sum}, {31'b0, 1'b1, 32'd2});
        check("stall_in_ready", {63'b0, in_ready}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold", {31'b0, out_valid, res_sum}, {31'b0, 1'b1, 32'd2});
            check("stall_hold_ready", {63'b0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("drain_4", {31'b0, out_valid, res_sum}, {31'b0, 1'b1, 32'd4});
        step();
        check("drain_6", {31'b0, out_valid, res_sum}, {31'b0, 1'b1, 32'd6});
        step();
        check("drain_done", {63'b0, out_valid}, 64'd0);

        // Reset pulse with ops in flight
        in_valid = 1'b1; a = 32'd10; b = 32'd20;
        step();
        a = 32'd30; b = 32'd40;
        step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_async", {63'b0, out_valid}, 64'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("midrst_flushed", {63'b0, out_valid}, 64'd0);
            step();
        end
        run_single("post_rst", 32'd5, 32'd7, 1'b0, 1'b0, 1'b0);
        check("post_rst_lit", {32'b0, res_sum}, {32'b0, 32'd12});
        step();

        // Random traffic with random back-pressure against the scoreboard
        q.delete();
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (out_valid) begin
                if (q.size() == 0) check("rand_spurious", {63'b0, out_valid}, 64'd0);
                else               check("rand", observed(), {29'b0, q[0]});
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0:       a = 32'h8000_0000;
                1:       a = 32'h7FFF_FFFF;
                2:       a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            b    = ($urandom_range(0, 4) == 0) ? 32'h0000_FFFF : $urandom;
            c_in = $urandom_range(0, 1) == 1;
            sub  = $urandom_range(0, 1) == 1;
`ifdef CLA_SATURATE_EN
            sat  = $urandom_range(0, 1) == 1;
`endif
            #1;
            acc   = in_valid && in_ready;
            drn   = out_valid && out_ready;
            e_new = model(a, b, c_in, sub, sat);
            step();
            if (drn && q.size() != 0) void'(q.pop_front());
            if (acc) q.push_back(e_new);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (out_valid && q.size() != 0) begin
                check("rand_tail", observed(), {29'b0, q[0]});
                void'(q.pop_front());
            end
            step();
        end
        check("rand_all_drained", {32'b0, q.size()}, 64'd0);
        check("rand_idle_valid", {63'b0, out_valid}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
